// File: rtl/clk_rst_activity_monitor.sv
// clk_rst_activity_monitor
//   Counts rising edges on NUM_CH pre-synchronized heartbeat inputs over a
//   fixed WINDOW of pl_clk0 cycles. It flags channels that are stuck (too few
//   edges) or over-fast (too many edges), and measures how many cycles each
//   channel's reset takes to release after measurement starts.
//
//   Ports
//     pl_clk0, pl0_resetn   : clock and synchronous active-low reset
//     enable                : run the monitor; low returns to IDLE
//     clear                 : clears the sticky ch_stuck / ch_fast flags
//     ch_toggle, ch_rst_n   : per-channel heartbeat and reset status, both
//                             already synchronized to pl_clk0
//     edge_cnt, cnt_valid   : last completed window count (ch0 in the LSBs)
//                             and a one-cycle update pulse
//     ch_ok                 : last window in range and channel released
//     ch_stuck, ch_fast     : sticky range violations
//     rst_seen,
//     rst_release_cnt       : reset-release observed, and its latency in cycles
//     state                 : 0=IDLE 1=SETTLE 2=MEASURE

// Per-channel edge counter, range check and reset-release timer.
module clk_rst_activity_lane #(
  parameter int CNT_W     = 16,
  parameter int MIN_EDGES = 4,
  parameter int MAX_EDGES = 600
) (
  input  logic             pl_clk0,
  input  logic             pl0_resetn,
  input  logic             active,     // MEASURE and still enabled
  input  logic             win_last,   // last cycle of the current window
  input  logic             arm,        // leaving IDLE: restart release timing
  input  logic             clear,
  input  logic             toggle,
  input  logic             rst_n_in,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ok,
  output logic             stuck,
  output logic             fast,
  output logic             rst_seen,
  output logic [CNT_W-1:0] rst_release_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_EDGES);

  logic             prev_toggle;
  logic             rise, too_low, too_high;
  logic [CNT_W-1:0] live_cnt, rel_cnt, cnt_total;

  // prev_toggle tracks the input in every state, so a level already high
  // when MEASURE starts is not mistaken for an edge.
  assign rise      = active & toggle & ~prev_toggle;
  // Live count including this cycle's edge, saturating.
  assign cnt_total = (live_cnt == CNT_MAX) ? CNT_MAX : live_cnt + CNT_W'(rise);
  assign too_low   = cnt_total < MIN_C;
  assign too_high  = cnt_total > MAX_C;

  always_ff @(posedge pl_clk0) begin
    if (!pl0_resetn) begin
      prev_toggle     <= 1'b0;
      live_cnt        <= '0;
      edge_cnt        <= '0;
      ok              <= 1'b0;
      stuck           <= 1'b0;
      fast            <= 1'b0;
      rel_cnt         <= '0;
      rst_seen        <= 1'b0;
      rst_release_cnt <= '0;
    end else begin
      prev_toggle <= toggle;

      if (win_last) begin
        edge_cnt <= cnt_total;
        ok       <= ~too_low & ~too_high & rst_n_in;
        live_cnt <= '0;
      end else if (active) begin
        live_cnt <= cnt_total;
      end else begin
        live_cnt <= '0;
      end

      // A new violation in the same cycle as clear wins; a channel held in
      // reset never updates its flags.
      stuck <= (stuck & ~clear) | (win_last & rst_n_in & too_low);
      fast  <= (fast  & ~clear) | (win_last & rst_n_in & too_high);

      if (arm) begin
        rel_cnt  <= '0;
        rst_seen <= 1'b0;
      end else if (active && !rst_seen) begin
        if (rst_n_in) begin
          rst_release_cnt <= rel_cnt;
          rst_seen        <= 1'b1;
        end else if (rel_cnt != CNT_MAX) begin
          rel_cnt <= rel_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

module clk_rst_activity_monitor #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int MIN_EDGES  = 4,
  parameter int MAX_EDGES  = 600,
  parameter int RST_SETTLE = 16
) (
  input  logic                    pl_clk0,
  input  logic                    pl0_resetn,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       ch_toggle,
  input  logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt,
  output logic                    cnt_valid,
  output logic [NUM_CH-1:0]       ch_ok,
  output logic [NUM_CH-1:0]       ch_stuck,
  output logic [NUM_CH-1:0]       ch_fast,
  output logic [NUM_CH-1:0]       rst_seen,
  output logic [NUM_CH*CNT_W-1:0] rst_release_cnt,
  output logic [1:0]              state
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SET_W = $clog2(RST_SETTLE + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(RST_SETTLE - 1);

  logic [WIN_W-1:0]             win_cnt;
  logic [SET_W-1:0]             settle_cnt;
  logic                         active, win_last, arm;
  logic [NUM_CH-1:0][CNT_W-1:0] edge_cnt_a, rel_a;

  // Dropping enable aborts the window in the same cycle: no edges counted,
  // no evaluation.
  assign active   = (state == ST_MEASURE) & enable;
  assign win_last = active & (win_cnt == WIN_LAST);
  assign arm      = (state == ST_IDLE) & enable;

  always_ff @(posedge pl_clk0) begin
    if (!pl0_resetn) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      cnt_valid  <= 1'b0;
    end else begin
      // Outputs latched at the end of the last window cycle, so the pulse
      // lines up with the new edge_cnt.
      cnt_valid <= win_last;
      if (!enable) begin
        state      <= ST_IDLE;
        settle_cnt <= '0;
        win_cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              state   <= ST_MEASURE;
              win_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          ST_MEASURE: win_cnt <= win_last ? '0 : win_cnt + WIN_W'(1);
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    clk_rst_activity_lane #(
      .CNT_W     (CNT_W),
      .MIN_EDGES (MIN_EDGES),
      .MAX_EDGES (MAX_EDGES)
    ) u_lane (
      .pl_clk0         (pl_clk0),
      .pl0_resetn      (pl0_resetn),
      .active          (active),
      .win_last        (win_last),
      .arm             (arm),
      .clear           (clear),
      .toggle          (ch_toggle[g]),
      .rst_n_in        (ch_rst_n[g]),
      .edge_cnt        (edge_cnt_a[g]),
      .ok              (ch_ok[g]),
      .stuck           (ch_stuck[g]),
      .fast            (ch_fast[g]),
      .rst_seen        (rst_seen[g]),
      .rst_release_cnt (rel_a[g])
    );
  end

  assign edge_cnt        = edge_cnt_a;
  assign rst_release_cnt = rel_a;
endmodule

// File: tb/tb_clk_rst_activity_monitor.sv
// Directed bench for clk_rst_activity_monitor with WINDOW=64, MIN_EDGES=4,
// MAX_EDGES=12, RST_SETTLE=16, NUM_CH=2. Heartbeats are generated from the
// bench's own count of MEASURE cycles, so each window's edge count is exact.
module tb_clk_rst_activity_monitor;
  localparam int NUM_CH = 2, CNT_W = 16, WINDOW = 64;
  localparam int MIN_EDGES = 4, MAX_EDGES = 12, RST_SETTLE = 16;

  logic        pl_clk0 = 1'b0;
  logic        pl0_resetn, enable, clear;
  logic [1:0]  ch_toggle, ch_rst_n;
  logic [31:0] edge_cnt, rst_release_cnt;
  logic        cnt_valid;
  logic [1:0]  ch_ok, ch_stuck, ch_fast, rst_seen, state;

  clk_rst_activity_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW(WINDOW),
    .MIN_EDGES(MIN_EDGES), .MAX_EDGES(MAX_EDGES), .RST_SETTLE(RST_SETTLE)
  ) dut (
    .pl_clk0(pl_clk0), .pl0_resetn(pl0_resetn), .enable(enable), .clear(clear),
    .ch_toggle(ch_toggle), .ch_rst_n(ch_rst_n), .edge_cnt(edge_cnt),
    .cnt_valid(cnt_valid), .ch_ok(ch_ok), .ch_stuck(ch_stuck), .ch_fast(ch_fast),
    .rst_seen(rst_seen), .rst_release_cnt(rst_release_cnt), .state(state)
  );

  always #5 pl_clk0 = ~pl_clk0;

  int         n_chk, n_fail;
  int         st_m, sc_m, m;          // bench FSM model: state, settle count, MEASURE cycle
  int         mode [2];
  logic [1:0] pre_hi;
  bit         clr_mid, clr_last;

  typedef struct {
    int          m0, m1;
    logic [1:0]  rst;
    bit          cm, cl;              // clear at window cycle 10 / at the last window cycle
    logic [15:0] e0, e1;
    logic [1:0]  ok, stuck, fast;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Heartbeat patterns, all low at window cycle 0 so a mode switch at the
  // window boundary never creates or hides an edge.
  function automatic logic tog_of(input int md, input int w);
    case (md)
      1:       return (w % 8) == 1;                 // 8 edges
      2:       return (w % 2) == 1;                 // 32 edges
      3:       return (w % 16) == 1;                // 4 edges
      4:       return ((w % 2) == 1) && (w < 24);   // 12 edges
      5:       return ((w % 16) == 1) && (w < 48);  // 3 edges
      6:       return ((w % 2) == 1) && (w < 26);   // 13 edges
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge pl_clk0);
    if (!pl0_resetn || !enable) begin
      st_m = 0; sc_m = 0; m = -1;
    end else begin
      case (st_m)
        0: begin st_m = 1; sc_m = 0; end
        1: if (sc_m == RST_SETTLE - 1) begin st_m = 2; m = 0; end else sc_m++;
        default: m++;
      endcase
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      if (st_m != 2)                  ch_toggle[c] = pre_hi[c];
      else if (m == 0 && pre_hi[c])   ch_toggle[c] = 1'b1;
      else                            ch_toggle[c] = tog_of(mode[c], m % WINDOW);
    end
    if (st_m == 2 && (m % WINDOW) == WINDOW - 1) clear = clr_last;
    else if (st_m == 2 && (m % WINDOW) == 10)    clear = clr_mid;
    else                                         clear = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_k);
    int k;
    k = 0;
    do begin tick(); k++; end while (!cnt_valid && k < 200);
    chk({name, "_valid_at"}, k, exp_k);
  endtask

  task automatic chk_rec(input int i);
    chk($sformatf("r%0d_edge0", i), edge_cnt[15:0],  tbl[i].e0);
    chk($sformatf("r%0d_edge1", i), edge_cnt[31:16], tbl[i].e1);
    chk($sformatf("r%0d_ok", i),    ch_ok,    tbl[i].ok);
    chk($sformatf("r%0d_stuck", i), ch_stuck, tbl[i].stuck);
    chk($sformatf("r%0d_fast", i),  ch_fast,  tbl[i].fast);
  endtask

  initial begin
    int k, nv;
    //            m0 m1 rst    cm    cl    e0      e1      ok     stuck  fast
    tbl[0] = '{1, 0, 2'b11, 1'b0, 1'b0, 16'd8,  16'd0,  2'b01, 2'b10, 2'b00};
    tbl[1] = '{1, 1, 2'b11, 1'b0, 1'b0, 16'd8,  16'd8,  2'b11, 2'b10, 2'b00};
    tbl[2] = '{3, 4, 2'b11, 1'b1, 1'b0, 16'd4,  16'd12, 2'b11, 2'b00, 2'b00};
    tbl[3] = '{2, 1, 2'b11, 1'b0, 1'b1, 16'd32, 16'd8,  2'b10, 2'b00, 2'b01};
    tbl[4] = '{1, 5, 2'b11, 1'b0, 1'b0, 16'd8,  16'd3,  2'b01, 2'b10, 2'b01};
    tbl[5] = '{6, 0, 2'b01, 1'b1, 1'b0, 16'd13, 16'd0,  2'b00, 2'b00, 2'b01};
    tbl[6] = '{1, 0, 2'b01, 1'b0, 1'b1, 16'd8,  16'd0,  2'b01, 2'b00, 2'b00};

    n_chk = 0; n_fail = 0; st_m = 0; sc_m = 0; m = -1;
    pre_hi = 2'b00;
    mode[0] = tbl[0].m0; mode[1] = tbl[0].m1;
    clr_mid = tbl[0].cm; clr_last = tbl[0].cl;
    pl0_resetn = 1'b0; enable = 1'b0; clear = 1'b0;
    ch_toggle = 2'b00; ch_rst_n = tbl[0].rst;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_valid", cnt_valid, 0);
    chk("rst_flags", {ch_ok, ch_stuck, ch_fast, rst_seen}, 0);
    chk("rst_release", rst_release_cnt, 0);

    // Startup: one IDLE cycle, 16 SETTLE cycles, then the first pulse in
    // the 65th MEASURE cycle (index 64).
    pl0_resetn = 1'b1; enable = 1'b1;
    tick();
    chk("state_settle", state, 1);
    k = 1;
    while (state == 2'd1 && k < 40) begin tick(); if (state == 2'd1) k++; end
    chk("settle_cycles", k, 16);
    chk("state_measure", state, 2);
    k = 0;
    while (!cnt_valid && k < 200) begin tick(); k++; end
    chk("first_valid_at", k, 64);

    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        mode[0] = tbl[i].m0; mode[1] = tbl[i].m1; ch_rst_n = tbl[i].rst;
        clr_mid = tbl[i].cm; clr_last = tbl[i].cl;
        wait_valid($sformatf("r%0d", i), 64);
      end
      chk_rec(i);
    end
    // Both released at MEASURE entry; later deassertion of ch1 must not re-arm.
    chk("tbl_rst_seen", rst_seen, 2'b11);
    chk("tbl_release", rst_release_cnt, 0);
    clr_mid = 1'b0; clr_last = 1'b0;
    tick();
    chk("valid_pulse_width", cnt_valid, 0);

    // enable low mid-window: IDLE next cycle, results hold, no pulses.
    enable = 1'b0;
    tick();
    chk("dis_state", state, 0);
    nv = 0;
    for (int j = 0; j < 80; j++) begin tick(); if (cnt_valid) nv++; end
    chk("dis_no_valid", nv, 0);
    chk("dis_edge_hold", edge_cnt, 32'h0000_0008);
    chk("dis_ok_hold", ch_ok, 2'b01);

    // Run A: ch0 heartbeat high through SETTLE and MEASURE cycle 0 (no edge
    // there, so 7 edges), ch1 held in reset for the whole window.
    pre_hi = 2'b01; mode[0] = 1; mode[1] = 0; ch_rst_n = 2'b01;
    enable = 1'b1;
    tick();
    chk("rearm_seen", rst_seen, 2'b00);
    wait_valid("runA", 80);
    chk("runA_edge", edge_cnt, 32'h0000_0007);
    chk("runA_ok", ch_ok, 2'b01);
    chk("runA_stuck", ch_stuck, 2'b00);
    chk("runA_seen", rst_seen, 2'b01);
    chk("runA_release", rst_release_cnt, 0);

    // Run B: ch1 released 37 cycles into MEASURE.
    enable = 1'b0; tick();
    pre_hi = 2'b00; enable = 1'b1;
    k = 0;
    while (!(st_m == 2 && m == 37) && k < 200) begin tick(); k++; end
    chk("runB_seen_before", rst_seen, 2'b01);
    ch_rst_n = 2'b11;
    tick();
    chk("runB_seen_after", rst_seen, 2'b11);
    chk("runB_release1", rst_release_cnt[31:16], 37);
    chk("runB_release0", rst_release_cnt[15:0], 0);
    wait_valid("runB", 26);
    chk("runB_edge", edge_cnt, 32'h0000_0008);
    chk("runB_stuck", ch_stuck, 2'b10);

    // One-cycle reset at window cycle 30 clears everything.
    k = 0;
    while ((m % WINDOW) != 30 && k < 200) begin tick(); k++; end
    pl0_resetn = 1'b0;
    tick();
    pl0_resetn = 1'b1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_edge", edge_cnt, 0);
    chk("mid_rst_valid", cnt_valid, 0);
    chk("mid_rst_flags", {ch_ok, ch_stuck, ch_fast, rst_seen}, 0);
    chk("mid_rst_release", rst_release_cnt, 0);
    mode[0] = 1; mode[1] = 1;
    wait_valid("post_rst", 81);
    chk("post_rst_edge", edge_cnt, 32'h0008_0008);
    chk("post_rst_ok", ch_ok, 2'b11);

    // enable low at window cycle 20: partial window dropped, edge_cnt holds.
    k = 0;
    while ((m % WINDOW) != 20 && k < 200) begin tick(); k++; end
    enable = 1'b0;
    tick();
    chk("abort_state", state, 0);
    nv = 0;
    for (int j = 0; j < 80; j++) begin tick(); if (cnt_valid) nv++; end
    chk("abort_no_valid", nv, 0);
    chk("abort_edge_hold", edge_cnt, 32'h0008_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
